uart_tx_mmio: RTL and testbench

//  Memory-mapped UART transmitter that answers the core's data-memory bus (load/store responder).

---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_tx_mmio.sv | 185 ++++++++++++++++++
 tb/tb_uart_tx_mmio.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the memory-mapped UART transmitter.
//   - FSM state encoding
//   - register offsets, decoded from Address_i[3:2]
//   - STATUS bit positions
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO used as the UART transmit queue.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   push, wdata      enqueue request and data; ignored when full unless popping too
//   pop, rdata       dequeue request; rdata shows the head entry
//   full, empty      occupancy flags
//   count            number of stored entries (0..DEPTH)
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    // A push into a full FIFO still lands when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped UART transmitter (8N1, LSB first) on the data bus.
// Register map (Address_i[3:2]): 0 TXDATA (W push), 1 STATUS (R, W1C overflow),
//   2 BAUD_DIV (R/W [15:0], 0 stored as 1), 3 reserved.
// Ports:
//   clk, reset               clock, asynchronous active-low reset
//   sel_i                    address decoder hit
//   Mem_Write_i, Mem_Read_i  store / load strobes
//   Address_i, Write_Data_i  bus address and store data
//   Read_Data_o              combinational load data, 0 unless selected load
//   tx_o                     serial line, idle high
//   irq_o                    FIFO empty and transmitter idle
// Build option: define UART_TX_PARITY_EN to append an even-parity bit (11-bit frame).
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = 434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel_i,
    input  logic        Mem_Write_i,
    input  logic        Mem_Read_i,
    input  logic [31:0] Address_i,
    input  logic [31:0] Write_Data_i,
    output logic [31:0] Read_Data_o,
    output logic        tx_o,
    output logic        irq_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_state_e state, state_nxt;
    logic [15:0] baud_div, baud_cnt;
    logic [7:0]  shreg, fifo_rdata;
    logic [2:0]  bit_cnt;
    logic        overflow;
    logic        fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CW-1:0] fifo_count;
    logic        frame_load, bit_shift, bit_done, bus_wr;
    logic [1:0]  reg_sel;
    logic [31:0] rd_mux;
`ifdef UART_TX_PARITY_EN
    logic        par_bit;
`endif

    logic unused_bits;
    assign unused_bits = ^{Address_i[31:4], Address_i[1:0], Write_Data_i[31:16]};

    assign reg_sel   = Address_i[3:2];
    assign bus_wr    = sel_i & Mem_Write_i;
    assign fifo_push = bus_wr & (reg_sel == REG_TXDATA);
    assign bit_done  = (baud_cnt == 16'd1);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (Write_Data_i[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Register writes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_div <= 16'(DEFAULT_DIV);
            overflow <= 1'b0;
        end else begin
            if (fifo_push & fifo_full & ~fifo_pop)
                overflow <= 1'b1;
            else if (bus_wr & (reg_sel == REG_STATUS) & Write_Data_i[STAT_OVF])
                overflow <= 1'b0;
            if (bus_wr & (reg_sel == REG_BAUD))
                baud_div <= (Write_Data_i[15:0] == 16'd0) ? 16'd1 : Write_Data_i[15:0];
        end
    end

    // Read mux
    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_STATUS: begin
                rd_mux[STAT_CNT_LSB +: 4] = 4'(fifo_count);
                rd_mux[STAT_OVF]          = overflow;
                rd_mux[STAT_EMPTY]        = fifo_empty;
                rd_mux[STAT_FULL]         = fifo_full;
                rd_mux[STAT_BUSY]         = (state != ST_IDLE);
            end
            REG_BAUD: rd_mux[15:0] = baud_div;
            default:  rd_mux = '0;
        endcase
    end

    assign Read_Data_o = (sel_i & Mem_Read_i) ? rd_mux : 32'd0;
    assign irq_o       = fifo_empty & (state == ST_IDLE);

    // FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        fifo_pop   = 1'b0;
        frame_load = 1'b0;
        bit_shift  = 1'b0;
        tx_o       = 1'b1;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt  = ST_START;
                    fifo_pop   = 1'b1;
                    frame_load = 1'b1;
                end
            end
            ST_START: begin
                tx_o = 1'b0;
                if (bit_done) state_nxt = ST_DATA;
            end
            ST_DATA: begin
                tx_o = shreg[0];
                if (bit_done) begin
                    bit_shift = 1'b1;
`ifdef UART_TX_PARITY_EN
                    if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
`else
                    if (bit_cnt == 3'd7) state_nxt = ST_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                tx_o = par_bit;
                if (bit_done) state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                // Next frame starts on the stop boundary itself: no idle gap.
                if (bit_done) begin
                    if (!fifo_empty) begin
                        state_nxt  = ST_START;
                        fifo_pop   = 1'b1;
                        frame_load = 1'b1;
                    end else begin
                        state_nxt  = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Baud counter and shift register; the divider is sampled at every reload,
    // so a mid-frame BAUD_DIV write takes effect from the next bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= 16'd1;
        end else if (frame_load) begin
            shreg    <= fifo_rdata;
            bit_cnt  <= '0;
            baud_cnt <= baud_div;
        end else if (state != ST_IDLE) begin
            baud_cnt <= bit_done ? baud_div : (baud_cnt - 16'd1);
            if (bit_shift) begin
                shreg   <= {1'b0, shreg[7:1]};
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          par_bit <= 1'b0;
        else if (frame_load) par_bit <= ^fifo_rdata;
    end
`endif

endmodule

// File: tb/tb_uart_tx_mmio.sv
module tb_uart_tx_mmio;
    localparam int DEPTH = 4;
    localparam int DEF_DIV = 434;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0, reset = 1'b0, sel = 1'b0, wr = 1'b0, rd = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [31:0] rdata;
    logic tx, irq;

    always #5 clk = ~clk;

    uart_tx_mmio #(.FIFO_DEPTH(DEPTH), .DEFAULT_DIV(DEF_DIV)) dut (
        .clk(clk), .reset(reset), .sel_i(sel), .Mem_Write_i(wr), .Mem_Read_i(rd),
        .Address_i(addr), .Write_Data_i(wdata), .Read_Data_o(rdata),
        .tx_o(tx), .irq_o(irq)
    );

    int nvec = 0, nmis = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a byte queue plus the start edge of the frame on the line.
    logic [7:0] q[$];
    bit         active = 0, movf = 0;
    longint     cyc = 0, fstart = 0;
    int         fdiv = 1, mdiv = DEF_DIV;
    logic [7:0] fbyte = '0;

    function automatic logic m_tx();
        longint k;
        if (!active) return 1'b1;
        k = (cyc - fstart) / fdiv;
        if (k == 0) return 1'b0;
        if (k <= 8) return fbyte[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return ^fbyte;
`endif
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] r = '0;
        case (a[3:2])
            2'd1: r = (32'(q.size()) << 4) | (32'(movf) << 3) | (32'(q.size() == 0) << 2)
                      | (32'(q.size() == DEPTH) << 1) | 32'(active);
            2'd2: r = 32'(mdiv);
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic m_reset();
        q.delete(); active = 0; movf = 0; mdiv = DEF_DIV;
    endtask

    task automatic model_edge();
        cyc++;
        if (!reset) return;
        if (active && cyc == fstart + longint'(NB * fdiv)) active = 0;
        if (!active && q.size() > 0) begin
            fbyte = q.pop_front(); fstart = cyc; fdiv = mdiv; active = 1;
        end
        if (sel && wr) begin
            case (addr[3:2])
                2'd0: if (q.size() < DEPTH) q.push_back(wdata[7:0]); else movf = 1;
                2'd1: if (wdata[3]) movf = 0;
                2'd2: mdiv = (wdata[15:0] == 0) ? 1 : int'(wdata[15:0]);
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check("tx_o", {31'd0, tx}, {31'd0, m_tx()});
        check("irq_o", {31'd0, irq}, {31'd0, (!active && q.size() == 0)});
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        sel = 1; wr = 1; addr = a; wdata = d;
        tick();
        sel = 0; wr = 0;
    endtask

    task automatic rd_model(input string name, input logic [31:0] a);
        sel = 1; rd = 1; addr = a; #1;
        check(name, rdata, m_read(a));
        sel = 0; rd = 0;
    endtask

    task automatic rd_const(input string name, input logic [31:0] a, input logic [31:0] exp);
        sel = 1; rd = 1; addr = a; #1;
        check(name, rdata, exp);
        sel = 0; rd = 0;
    endtask

    task automatic drain(input int max);
        int n = 0;
        while (!irq && n < max) begin tick(); n++; end
        check("drain_irq", {31'd0, irq}, 32'd1);
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[13];
    logic [10:0] pat;

    initial begin
        tbl[0]  = '{0, 32'h4, 0, 32'h4};
        tbl[1]  = '{0, 32'h8, 0, 32'd434};
        tbl[2]  = '{0, 32'h0, 0, 32'h0};
        tbl[3]  = '{0, 32'hC, 0, 32'h0};
        tbl[4]  = '{1, 32'h8, 32'h0, 0};
        tbl[5]  = '{0, 32'h8, 0, 32'h1};
        tbl[6]  = '{1, 32'h8, 32'hABCD_1234, 0};
        tbl[7]  = '{0, 32'h8, 0, 32'h1234};
        tbl[8]  = '{1, 32'hC, 32'hFFFF_FFFF, 0};
        tbl[9]  = '{0, 32'hC, 0, 32'h0};
        tbl[10] = '{1, 32'h4, 32'hFFFF_FFFF, 0};
        tbl[11] = '{1, 32'h1008, 32'h4, 0};
        tbl[12] = '{0, 32'h8, 0, 32'h4};

        // Reset
        repeat (3) tick();
        reset = 1'b1;
        m_reset();
        rd_const("reset_status", 32'h4, 32'h4);
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd1);
        sel = 0; rd = 1; addr = 32'h4; #1;
        check("rdata_unselected", rdata, 32'd0);
        rd = 0; sel = 1; #1;
        check("rdata_no_read", rdata, 32'd0);
        sel = 0;

        // Register table
        foreach (tbl[i]) begin
            if (tbl[i].is_wr) store(tbl[i].a, tbl[i].d);
            else begin
                rd_const($sformatf("tbl%0d", i), tbl[i].a, tbl[i].exp);
                tick();
            end
        end

        // 0x55 at BAUD_DIV=4, explicit waveform
`ifdef UART_TX_PARITY_EN
        pat = 11'b1_0_01010101_0;
`else
        pat = 11'b0_1_01010101_0;
`endif
        store(32'h0, 32'h55);
        for (int i = 0; i < NB * 4; i++) begin
            tick();
            check($sformatf("frame55_bit%0d", i / 4), {31'd0, tx}, {31'd0, pat[i / 4]});
            sel = 1; rd = 1; addr = 32'h4; #1;
            check("frame55_busy", {31'd0, rdata[0]}, 32'd1);
            sel = 0; rd = 0;
        end
        tick();
        check("frame55_irq_after", {31'd0, irq}, 32'd1);

        // Overflow at BAUD_DIV=100, then reset mid-DATA
        store(32'h8, 32'd100);
        for (int i = 0; i < 6; i++) store(32'h0, 32'(i * 17));
        rd_const("ovf_status", 32'h4, 32'h4B);
        store(32'h4, 32'h8);
        rd_const("ovf_cleared", 32'h4, 32'h43);
        repeat (150) tick();
        check("mid_data_low", {31'd0, tx}, 32'd0);
        #2 reset = 1'b0;
        m_reset();
        #1 check("async_reset_tx", {31'd0, tx}, 32'd1);
        repeat (2) tick();
        reset = 1'b1;
        rd_const("post_reset_status", 32'h4, 32'h4);
        rd_const("post_reset_baud", 32'h8, 32'd434);

        // Back-to-back frames at BAUD_DIV=2
        store(32'h8, 32'd2);
        store(32'h0, 32'hA5);
        store(32'h0, 32'h3C);
        for (int i = 0; i < 4 * NB - 1; i++) begin
            tick();
            check("b2b_no_idle", {31'd0, irq}, 32'd0);
            if (i == 2 * NB - 1) check("b2b_second_start", {31'd0, tx}, 32'd0);
        end
        tick();
        check("b2b_irq_end", {31'd0, irq}, 32'd1);

`ifdef UART_TX_PARITY_EN
        store(32'h0, 32'h07);
        repeat (19) tick();
        check("parity_07", {31'd0, tx}, 32'd1);
        drain(100);
        store(32'h0, 32'h03);
        repeat (19) tick();
        check("parity_03", {31'd0, tx}, 32'd0);
        drain(100);
`endif

        // Randomized traffic against the model
        store(32'h8, 32'($urandom_range(2, 5)));
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 15))
                0, 1: store(32'h0, $urandom);
                2:    store(32'h4, $urandom);
                3:    store(32'hC, $urandom);
                4:    begin rd_model("rand_status", 32'h4); tick(); end
                default: tick();
            endcase
        end
        drain(2000);
        rd_model("final_status", 32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
